cmac_column_drain: RTL and testbench

- Sits at the bottom of each CMAC column and terminates the partial-sum / error-product chain.
- The last CMAC in a column may forward a nonzero error_product (a deferred product after a timing-error replay). No downstream PE exists to absorb it, so this block adds it into the partial sum.
- Completed column results are buffered in a small FIFO and presented to the output collector with a valid/ready handshake.
- The block also keeps saturating statistics on compensation events and dropped results.

---
 rtl/cmac_column_drain.sv | 158 +++++++++++++++
 tb/tb_cmac_column_drain.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_column_drain.sv
// ============================================================================
//  Module      : cmac_column_drain
//  Description : Terminates a CMAC column. Folds the last PE's deferred
//                error product into its partial sum, buffers finished column
//                results in a first-word-fall-through FIFO with a
//                valid/ready output, and keeps saturating statistics on
//                compensated and dropped words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmac_column_drain #(
    parameter int PSUM_W = 24,
    parameter int EP_W   = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [PSUM_W-1:0]          partial_sum_in,
    input  logic [EP_W-1:0]            error_product_in,
    input  logic                       error_sig_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PSUM_W-1:0]          result_out,
    output logic                       corrected_out,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CNT_W-1:0]           err_count,
    output logic [CNT_W-1:0]           drop_count,
    output logic                       overflow,
    input  logic                       clr_stats
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    C_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0]    C_CNT_ONE  = CW'(1);
    localparam logic [AW-1:0]    C_PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] C_STAT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_STAT_MAX = {CNT_W{1'b1}};

    // Stage 1 capture registers
    logic                r_s1_valid;
    logic [PSUM_W-1:0]   r_s1_psum;
    logic [EP_W-1:0]     r_s1_ep;
    logic                r_s1_err;

    // FIFO storage and bookkeeping
    logic [PSUM_W-1:0]   r_mem_data [DEPTH];
    logic                r_mem_corr [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;

    logic [CNT_W-1:0]    r_err_count;
    logic [CNT_W-1:0]    r_drop_count;
    logic                r_overflow;

    logic [PSUM_W-1:0]   w_sum;
    logic                w_corr;
    logic                w_pop;
    logic                w_push_ok;
    logic                w_drop;

    // Stage 2: fold the deferred product in (wrapping add) and flag compensation
    always_comb begin
        w_sum     = r_s1_psum + PSUM_W'(r_s1_ep);
        w_corr    = r_s1_err | (r_s1_ep != '0);
        w_pop     = out_valid & out_ready;
        // A full FIFO still takes the word when the head leaves this cycle
        w_push_ok = r_s1_valid & ((r_count < C_DEPTH) | w_pop);
        w_drop    = r_s1_valid & ~w_push_ok;
    end

    // Stage 1: capture the column word; data holds when nothing arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_psum  <= '0;
            r_s1_ep    <= '0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_psum <= partial_sum_in;
                r_s1_ep   <= error_product_in;
                r_s1_err  <= error_sig_in;
            end
        end
    end

    // FIFO storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_data[r_wptr] <= w_sum;
            r_mem_corr[r_wptr] <= w_corr;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + C_PTR_ONE;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + C_CNT_ONE;
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - C_CNT_ONE;
            end
        end
    end

    // Saturating statistics; a clear takes priority over any same-cycle event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count  <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else if (clr_stats) begin
            r_err_count  <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (r_s1_valid && w_corr && (r_err_count != C_STAT_MAX)) begin
                r_err_count <= r_err_count + C_STAT_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != C_STAT_MAX) begin
                    r_drop_count <= r_drop_count + C_STAT_ONE;
                end
            end
        end
    end

    // Head presentation; zeroed while empty so reset shows clean outputs
    always_comb begin
        out_valid     = (r_count != '0);
        result_out    = out_valid ? r_mem_data[r_rptr] : '0;
        corrected_out = out_valid ? r_mem_corr[r_rptr] : 1'b0;
        fifo_count    = r_count;
        err_count     = r_err_count;
        drop_count    = r_drop_count;
        overflow      = r_overflow;
    end

endmodule

`default_nettype wire

// File: tb/tb_cmac_column_drain.sv
// ============================================================================
//  Module      : tb_cmac_column_drain
//  Description : Directed self-checking bench for cmac_column_drain. A small
//                behavioural model holds the expected FIFO contents as a
//                scoreboard queue alongside the expected statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmac_column_drain;

    localparam int PSUM_W = 24;
    localparam int EP_W   = 16;
    localparam int DEPTH  = 8;
    // Narrow counters so saturation is reachable in a few hundred cycles
    localparam int CNT_W  = 8;
    localparam logic [CNT_W-1:0] C_STAT_MAX = {CNT_W{1'b1}};

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic [PSUM_W-1:0]      partial_sum_in;
    logic [EP_W-1:0]        error_product_in;
    logic                   error_sig_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [PSUM_W-1:0]      result_out;
    logic                   corrected_out;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [CNT_W-1:0]       err_count;
    logic [CNT_W-1:0]       drop_count;
    logic                   overflow;
    logic                   clr_stats;

    cmac_column_drain #(
        .PSUM_W (PSUM_W),
        .EP_W   (EP_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .partial_sum_in   (partial_sum_in),
        .error_product_in (error_product_in),
        .error_sig_in     (error_sig_in),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result_out       (result_out),
        .corrected_out    (corrected_out),
        .fifo_count       (fifo_count),
        .err_count        (err_count),
        .drop_count       (drop_count),
        .overflow         (overflow),
        .clr_stats        (clr_stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected model state; q is the scoreboard of {result, corrected}
    logic [PSUM_W:0]   q[$];
    logic              m_s1_v    = 1'b0;
    logic [PSUM_W:0]   m_s1_word = '0;
    logic [CNT_W-1:0]  m_err     = '0;
    logic [CNT_W-1:0]  m_drop    = '0;
    logic              m_ovf     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        if (q.size() != 0) begin
            check("result_out", 32'(result_out), 32'(q[0][PSUM_W:1]));
            check("corrected_out", 32'(corrected_out), 32'(q[0][0]));
        end
        check("err_count", 32'(err_count), 32'(m_err));
        check("drop_count", 32'(drop_count), 32'(m_drop));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // One clock: drive inputs, compare current outputs, advance the model at the edge
    task automatic cycle(input bit v, input logic [PSUM_W-1:0] ps, input logic [EP_W-1:0] ep,
                         input bit er, input bit rdy, input bit clr);
        bit pop;
        bit push;
        bit acc;
        logic [PSUM_W-1:0] sum;
        in_valid         = v;
        partial_sum_in   = ps;
        error_product_in = ep;
        error_sig_in     = er;
        out_ready        = rdy;
        clr_stats        = clr;
        check_model();
        pop  = rdy && (q.size() != 0);
        push = m_s1_v;
        acc  = push && ((q.size() < DEPTH) || pop);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(m_s1_word);
        if (clr) begin
            m_err  = '0;
            m_drop = '0;
            m_ovf  = 1'b0;
        end else begin
            if (push && m_s1_word[0] && (m_err != C_STAT_MAX)) m_err = m_err + 1'b1;
            if (push && !acc) begin
                m_ovf = 1'b1;
                if (m_drop != C_STAT_MAX) m_drop = m_drop + 1'b1;
            end
        end
        m_s1_v = v;
        if (v) begin
            sum       = ps + {{(PSUM_W-EP_W){1'b0}}, ep};
            m_s1_word = {sum, er | (ep != '0)};
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, '0, '0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        rst              = 1'b1;
        in_valid         = 1'b0;
        partial_sum_in   = '0;
        error_product_in = '0;
        error_sig_in     = 1'b0;
        out_ready        = 1'b0;
        clr_stats        = 1'b0;
        @(posedge clk);
        #1;
        // Reset state
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst fifo_count", 32'(fifo_count), 32'd0);
        check("rst result_out", 32'(result_out), 32'd0);
        check("rst err_count", 32'(err_count), 32'd0);
        rst = 1'b0;

        // Clean word with two-edge latency
        cycle(1'b1, 24'h000100, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("lat1 out_valid", 32'(out_valid), 32'd0);
        idle(1'b0);
        check("clean out_valid", 32'(out_valid), 32'd1);
        check("clean result", 32'(result_out), 32'h000100);
        check("clean corrected", 32'(corrected_out), 32'd0);
        check("clean err_count", 32'(err_count), 32'd0);
        idle(1'b1);
        idle(1'b1);

        // Compensated words, second one wraps
        cycle(1'b1, 24'h00FFFF, 16'hFE01, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 24'hFFFFF0, 16'h0020, 1'b0, 1'b1, 1'b0);
        check("comp result", 32'(result_out), 32'h01FE00);
        check("comp corrected", 32'(corrected_out), 32'd1);
        check("comp err_count", 32'(err_count), 32'd1);
        idle(1'b1);
        check("wrap result", 32'(result_out), 32'h000010);
        check("wrap corrected", 32'(corrected_out), 32'd1);
        check("wrap err_count", 32'(err_count), 32'd2);
        idle(1'b1);
        idle(1'b1);

        // Overflow: ten words into an eight-deep FIFO with no drain
        for (int i = 1; i <= 10; i++) cycle(1'b1, 24'(i * 24'h111), 16'h0000, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("ovf fifo_count", 32'(fifo_count), 32'd8);
        check("ovf drop_count", 32'(drop_count), 32'd2);
        check("ovf overflow", 32'(overflow), 32'd1);
        check("ovf head", 32'(result_out), 32'h000111);
        for (int i = 0; i < 9; i++) idle(1'b1);

        // Full FIFO with simultaneous pop and push every cycle
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) cycle(1'b1, 24'(24'h100000 + i), 16'(i), 1'b0, 1'b0, 1'b0);
        check("full fifo_count", 32'(fifo_count), 32'd8);
        for (int i = 10; i <= 21; i++) cycle(1'b1, 24'(24'h100000 + i), 16'(i), 1'b0, 1'b1, 1'b0);
        check("fullpop fifo_count", 32'(fifo_count), 32'd8);
        check("fullpop drop_count", 32'(drop_count), 32'd0);
        check("fullpop overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 10; i++) idle(1'b1);

        // Asynchronous reset between edges: 3 buffered, 1 in stage 1
        for (int i = 1; i <= 4; i++) cycle(1'b1, 24'(24'h200000 + i), 16'h0000, 1'b1, 1'b0, 1'b0);
        check("pre-rst fifo_count", 32'(fifo_count), 32'd3);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("arst out_valid", 32'(out_valid), 32'd0);
        check("arst fifo_count", 32'(fifo_count), 32'd0);
        check("arst err_count", 32'(err_count), 32'd0);
        q.delete();
        m_s1_v = 1'b0;
        m_err  = '0;
        m_drop = '0;
        m_ovf  = 1'b0;
        #1;
        rst = 1'b0;
        cycle(1'b1, 24'hABCDEF, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("post-rst lat1", 32'(out_valid), 32'd0);
        idle(1'b0);
        check("post-rst valid", 32'(out_valid), 32'd1);
        check("post-rst result", 32'(result_out), 32'hABCDEF);
        idle(1'b1);

        // Saturation of err_count under a stream of compensated words
        for (int i = 0; i < 300; i++) cycle(1'b1, 24'(i), 16'h0001, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        check("sat err_count", 32'(err_count), 32'(C_STAT_MAX));
        idle(1'b1);

        // Clear wins over a same-cycle compensated word; FIFO keeps the word
        cycle(1'b1, 24'h000ABC, 16'h0004, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("clr err_count", 32'(err_count), 32'd0);
        check("clr fifo_count", 32'(fifo_count), 32'd1);
        check("clr result", 32'(result_out), 32'h000AC0);
        idle(1'b1);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
